// File: rtl/l1_bus_arbiter.sv
// l1_bus_arbiter: shares the single system bus between the I-side and D-side
// L1 caches. Round-robin between the two sides, the grant is held for a whole
// burst, and there is one idle (RELEASE) cycle between owners.
// Optional feature: define ARB_TIMEOUT_EN to add a watchdog. It ends a grant
// that waits too long for SYSready, and it sets the sticky arb_err flag.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | bus free; arbitrate among the strobes seen this cycle
// ST_GRANT_I | I-cache owns the bus while I_strobe stays high
// ST_GRANT_D | D-cache owns the bus while D_strobe stays high
// ST_RELEASE | one dead cycle with every output low, then ST_IDLE
module l1_bus_arbiter #(
   parameter int DATAWIDTH = 32,
   parameter int ADDRWIDTH = 32,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 I_strobe,
   input  logic                 I_rw,
   input  logic [ADDRWIDTH-1:0] I_addr,
   input  logic [DATAWIDTH-1:0] I_wdata,
   output logic                 I_ready,
   output logic [DATAWIDTH-1:0] I_rdata,
   input  logic                 D_strobe,
   input  logic                 D_rw,
   input  logic [ADDRWIDTH-1:0] D_addr,
   input  logic [DATAWIDTH-1:0] D_wdata,
   output logic                 D_ready,
   output logic [DATAWIDTH-1:0] D_rdata,
   output logic                 SYSstrobe,
   output logic                 SYSrw,
   output logic [ADDRWIDTH-1:0] SYSaddr,
   output logic [DATAWIDTH-1:0] SYSdata_out,
   input  logic                 SYSready,
   input  logic [DATAWIDTH-1:0] SYSdata_in,
   output logic [1:0]           grant,
   output logic                 arb_err
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT_I = 2'd1,
      ST_GRANT_D = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t state_q, state_d;
   // last side served: 0 = I, 1 = D
   logic   last_q, last_d;
   logic   in_grant;
   logic   timeout_hit;

   assign in_grant = (state_q == ST_GRANT_I) || (state_q == ST_GRANT_D);

`ifdef ARB_TIMEOUT_EN
   // The watchdog is a down-counter. It is reloaded with TIMEOUT whenever the
   // up-count would clear, so reaching zero here marks the same cycle as an
   // up-count reaching TIMEOUT.
   localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);

   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             arb_err_q, arb_err_d;

   // A ready in the same cycle wins over the timeout.
   assign timeout_hit = in_grant && !SYSready && (tmr_q == '0);

   // Watchdog next value: load on grant entry and on every ready, count down otherwise.
   always_comb begin
      tmr_d = tmr_q;
      case (state_q)
         ST_IDLE: begin
            if (state_d != ST_IDLE) tmr_d = TMR_LOAD;
         end
         ST_GRANT_I, ST_GRANT_D: begin
            if (SYSready)            tmr_d = TMR_LOAD;
            else if (tmr_q != '0)    tmr_d = tmr_q - TMR_W'(1);
         end
         default: tmr_d = tmr_q;
      endcase
   end

   // Sticky error flag, set by any timeout until reset.
   always_comb begin
      arb_err_d = arb_err_q | timeout_hit;
   end

   // Watchdog and error flag registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmr_q     <= '0;
         arb_err_q <= 1'b0;
      end else begin
         tmr_q     <= tmr_d;
         arb_err_q <= arb_err_d;
      end
   end

   assign arb_err = arb_err_q;
`else
   assign timeout_hit = 1'b0;
   assign arb_err     = 1'b0;
`endif

   // Next-state logic. A tie goes to the side that was not served last.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (I_strobe && D_strobe) state_d = last_q ? ST_GRANT_I : ST_GRANT_D;
            else if (I_strobe)        state_d = ST_GRANT_I;
            else if (D_strobe)        state_d = ST_GRANT_D;
         end
         ST_GRANT_I: begin
            if (!I_strobe || timeout_hit) begin
               state_d = ST_RELEASE;
               last_d  = 1'b0;
            end
         end
         ST_GRANT_D: begin
            if (!D_strobe || timeout_hit) begin
               state_d = ST_RELEASE;
               last_d  = 1'b1;
            end
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // State and round-robin history registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // Bus mux. Outputs are decoded from the registered state only, so reset
   // silences them immediately. On a timeout the owner gets a ready with zero data.
   always_comb begin
      SYSstrobe   = 1'b0;
      SYSrw       = 1'b0;
      SYSaddr     = '0;
      SYSdata_out = '0;
      I_ready     = 1'b0;
      D_ready     = 1'b0;
      I_rdata     = '0;
      D_rdata     = '0;
      case (state_q)
         ST_GRANT_I: begin
            SYSstrobe   = I_strobe;
            SYSrw       = I_rw;
            SYSaddr     = I_addr;
            SYSdata_out = I_wdata;
            I_ready     = SYSready | timeout_hit;
            I_rdata     = timeout_hit ? '0 : SYSdata_in;
         end
         ST_GRANT_D: begin
            SYSstrobe   = D_strobe;
            SYSrw       = D_rw;
            SYSaddr     = D_addr;
            SYSdata_out = D_wdata;
            D_ready     = SYSready | timeout_hit;
            D_rdata     = timeout_hit ? '0 : SYSdata_in;
         end
         default: begin
            SYSstrobe = 1'b0;
         end
      endcase
   end

   assign grant = {state_q == ST_GRANT_D, state_q == ST_GRANT_I};

endmodule

// File: tb/tb_l1_bus_arbiter.sv
// Testbench for l1_bus_arbiter. A transaction-level model tracks who owns
// the bus, the cool-down cycles, and the history of which side was served. All
// outputs are compared against this model on every falling edge. Directed
// literal checks pin down the main scenarios. A randomized phase follows.
module tb_l1_bus_arbiter;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 8;
   localparam int VW = 7 + AW + 3 * DW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          I_strobe = 1'b0, I_rw = 1'b0, D_strobe = 1'b0, D_rw = 1'b0;
   logic [AW-1:0] I_addr = '0, D_addr = '0;
   logic [DW-1:0] I_wdata = '0, D_wdata = '0;
   logic          I_ready, D_ready;
   logic [DW-1:0] I_rdata, D_rdata;
   logic          SYSstrobe, SYSrw;
   logic [AW-1:0] SYSaddr;
   logic [DW-1:0] SYSdata_out;
   logic          SYSready = 1'b0;
   logic [DW-1:0] SYSdata_in = '0;
   logic [1:0]    grant;
   logic          arb_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   l1_bus_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .I_strobe(I_strobe), .I_rw(I_rw), .I_addr(I_addr), .I_wdata(I_wdata),
      .I_ready(I_ready), .I_rdata(I_rdata),
      .D_strobe(D_strobe), .D_rw(D_rw), .D_addr(D_addr), .D_wdata(D_wdata),
      .D_ready(D_ready), .D_rdata(D_rdata),
      .SYSstrobe(SYSstrobe), .SYSrw(SYSrw), .SYSaddr(SYSaddr), .SYSdata_out(SYSdata_out),
      .SYSready(SYSready), .SYSdata_in(SYSdata_in),
      .grant(grant), .arb_err(arb_err)
   );

   // Reference model. owner: 0 = none, 1 = I, 2 = D. cool = dead cycle pending.
   // last = side served most recently. wait_n = no-ready cycles seen so far in this grant.
   int m_owner = 0;
   int m_cool  = 0;
   int m_last  = 1;
   int m_wait  = 0;
   bit m_err   = 1'b0;
   bit m_s;
   bit m_to;

   function automatic bit model_timeout();
`ifdef ARB_TIMEOUT_EN
      return (m_owner != 0) && !SYSready && (m_wait == TO);
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_owner = 0; m_cool = 0; m_last = 1; m_wait = 0; m_err = 1'b0;
      end else if (m_owner != 0) begin
         m_s  = (m_owner == 1) ? I_strobe : D_strobe;
         m_to = model_timeout();
         if (!m_s || m_to) begin
            m_last = m_owner; m_owner = 0; m_cool = 1;
            if (m_to) m_err = 1'b1;
         end else if (SYSready) m_wait = 0;
         else m_wait = m_wait + 1;
      end else if (m_cool != 0) begin
         m_cool = 0;
      end else begin
         if (I_strobe && D_strobe) m_owner = (m_last == 2) ? 1 : 2;
         else if (I_strobe)        m_owner = 1;
         else if (D_strobe)        m_owner = 2;
         m_wait = 0;
      end
   end

   function automatic logic [VW-1:0] model_out();
      logic [1:0]    g;
      logic          st, rw, ir, dr, to;
      logic [AW-1:0] a;
      logic [DW-1:0] wd, ird, drd;
      g = 2'b00; st = 1'b0; rw = 1'b0; ir = 1'b0; dr = 1'b0;
      a = '0; wd = '0; ird = '0; drd = '0;
      to = model_timeout();
      if (m_owner == 1) begin
         g = 2'b01; st = I_strobe; rw = I_rw; a = I_addr; wd = I_wdata;
         ir = SYSready | to; ird = to ? '0 : SYSdata_in;
      end else if (m_owner == 2) begin
         g = 2'b10; st = D_strobe; rw = D_rw; a = D_addr; wd = D_wdata;
         dr = SYSready | to; drd = to ? '0 : SYSdata_in;
      end
`ifdef ARB_TIMEOUT_EN
      return {g, m_err, st, rw, a, wd, ir, dr, ird, drd};
`else
      return {g, 1'b0, st, rw, a, wd, ir, dr, ird, drd};
`endif
   endfunction

   logic [VW-1:0] dut_vec;
   assign dut_vec = {grant, arb_err, SYSstrobe, SYSrw, SYSaddr, SYSdata_out,
                     I_ready, D_ready, I_rdata, D_rdata};

   task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) chk("cycle_outputs", dut_vec, model_out());

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] exp_g;

   initial begin
      // Hold reset with both strobes high.
      I_strobe = 1'b1; D_strobe = 1'b1; I_addr = 32'h0000_000A; D_addr = 32'h0000_000B;
      repeat (3) tick();
      #1;
      chk("rst_grant", grant, 2'b00);
      chk("rst_sysstrobe", SYSstrobe, 1'b0);
      chk("rst_sysaddr", SYSaddr, '0);
      rst = 1'b1;
      tick(); #1;
      chk("first_tie_grant", grant, 2'b10);
      chk("first_tie_sysaddr", SYSaddr, 32'h0000_000B);
      I_strobe = 1'b0; D_strobe = 1'b0;
      repeat (3) tick();

      // Single I read.
      I_strobe = 1'b1; I_rw = 1'b1; I_addr = 32'h0000_1000;
      tick(); #1;
      chk("iread_grant", grant, 2'b01);
      chk("iread_sysaddr", SYSaddr, 32'h0000_1000);
      SYSready = 1'b1; SYSdata_in = 32'h1234_5678; #1;
      chk("iread_ready", I_ready, 1'b1);
      chk("iread_rdata", I_rdata, 32'h1234_5678);
      chk("iread_d_ready", D_ready, 1'b0);
      tick(); SYSready = 1'b0; I_strobe = 1'b0;
      tick(); tick();

      // D four-word refill.
      D_strobe = 1'b1; D_rw = 1'b1; D_addr = 32'h0000_2000;
      tick();
      for (int k = 0; k < 4; k++) begin
         SYSready = 1'b1; SYSdata_in = 32'h0000_D000 + k; #1;
         chk("refill_grant", grant, 2'b10);
         chk("refill_ready", D_ready, 1'b1);
         tick(); SYSready = 1'b0; tick();
      end
      D_strobe = 1'b0; #1;
      chk("refill_last_grant", grant, 2'b10);
      tick(); #1;
      chk("refill_release", grant, 2'b00);
      tick(); #1;
      chk("refill_idle", grant, 2'b00);

      // Contention: I arrives while D bursts.
      D_strobe = 1'b1;
      tick(); I_strobe = 1'b1;
      tick(); tick(); #1;
      chk("cont_d_holds", grant, 2'b10);
      D_strobe = 1'b0;
      tick(); #1; chk("cont_gap1", grant, 2'b00);
      tick(); #1; chk("cont_gap2", grant, 2'b00);
      tick(); #1; chk("cont_i_granted", grant, 2'b01);
      I_strobe = 1'b0;
      tick(); tick();

      // Simultaneous requests alternate D, I, D, I.
      for (int r = 0; r < 4; r++) begin
         exp_g = (r % 2 == 0) ? 2'b10 : 2'b01;
         I_strobe = 1'b1; D_strobe = 1'b1;
         tick(); #1;
         chk("alternate", grant, exp_g);
         I_strobe = 1'b0; D_strobe = 1'b0;
         tick(); tick();
      end

      // Reset in the middle of an I burst.
      I_strobe = 1'b1;
      tick(); #1;
      chk("midrst_pre_grant", grant, 2'b01);
      chk("midrst_pre_strobe", SYSstrobe, 1'b1);
      rst = 1'b0; #1;
      chk("midrst_sysstrobe", SYSstrobe, 1'b0);
      chk("midrst_grant", grant, 2'b00);
      D_strobe = 1'b1;
      tick(); rst = 1'b1;
      tick(); #1;
      chk("midrst_tie", grant, 2'b10);
      I_strobe = 1'b0; D_strobe = 1'b0;
      tick(); tick();

`ifdef ARB_TIMEOUT_EN
      // Watchdog: I granted, SYSready never comes.
      SYSdata_in = 32'hDEAD_BEEF; SYSready = 1'b0; I_strobe = 1'b1; I_rw = 1'b1;
      tick();
      for (int c = 1; c <= TO; c++) begin
         #1; chk("to_wait_ready", I_ready, 1'b0);
         tick();
      end
      #1;
      chk("to_ready", I_ready, 1'b1);
      chk("to_rdata", I_rdata, '0);
      chk("to_err_before", arb_err, 1'b0);
      tick(); #1;
      chk("to_err_set", arb_err, 1'b1);
      chk("to_release", grant, 2'b00);
      I_strobe = 1'b0;
      tick(); tick();
      I_strobe = 1'b1;
      tick(); #1;
      chk("to_next_grant", grant, 2'b01);
      SYSready = 1'b1; SYSdata_in = 32'h55AA_55AA; #1;
      chk("to_next_ready", I_ready, 1'b1);
      chk("to_next_rdata", I_rdata, 32'h55AA_55AA);
      chk("to_err_sticky", arb_err, 1'b1);
      tick(); SYSready = 1'b0; I_strobe = 1'b0;
      tick(); tick();
`endif

      // Randomized traffic checked by the every-cycle compare.
      repeat (3000) begin
         if ($urandom_range(0, 3) == 0) I_strobe = ~I_strobe;
         if ($urandom_range(0, 3) == 0) D_strobe = ~D_strobe;
         I_rw       = 1'($urandom_range(0, 1));
         D_rw       = 1'($urandom_range(0, 1));
         I_addr     = $urandom;
         D_addr     = $urandom;
         I_wdata    = $urandom;
         D_wdata    = $urandom;
         SYSready   = 1'($urandom_range(0, 1));
         SYSdata_in = $urandom;
         rst        = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
